// File: rtl/spi_cmd_decoder_if.sv
// Bus bundle between the SPI bridge / PWM register file (master side) and
// the command decoder (slave side).
interface spi_cmd_decoder_if #(
    parameter int ADDR_W = 6
);
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_read;
    logic [7:0]        data_write;
    logic              err;

    modport master (
        output cs_n, byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write, err
    );

    modport slave (
        input  cs_n, byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write, err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Two-byte SPI command decoder (command, data) driving register read/write strobes.
// Optional burst mode with address auto-increment: define SPI_CMD_AUTOINC_EN.
module spi_cmd_decoder #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_cmd_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_WDATA = 2'd1,
        S_RDATA = 2'd2,
        S_SKIP  = 2'd3
    } state_t;

    // Command bits between ADDR_W and bit 5 that must be zero.
    localparam logic [5:0] HI_MASK = 6'(6'h3F << ADDR_W);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        data_write_reg, data_write_next;
    logic [7:0]        data_out_reg, data_out_next;
    logic              read_reg, read_next;
    logic              write_reg, write_next;
    logic              err_reg, err_next;
    logic              cs_n_q_reg;
    logic              clr_dout;
    logic              byte_ok;
    logic              illegal_cmd;
    logic              cap;

    assign illegal_cmd = bus.data_in[6] | (|(bus.data_in[5:0] & HI_MASK));

    // A byte coincident with cs_n rising still counts; once cs_n has been
    // high for a full cycle, byte_sync is ignored.
    assign byte_ok = bus.byte_sync & ~(bus.cs_n & cs_n_q_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_CMD;
            addr_reg       <= '0;
            data_write_reg <= '0;
            data_out_reg   <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            err_reg        <= 1'b0;
            cs_n_q_reg     <= 1'b1;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            data_write_reg <= data_write_next;
            data_out_reg   <= data_out_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            err_reg        <= err_next;
            cs_n_q_reg     <= bus.cs_n;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        data_write_next = data_write_reg;
        read_next       = 1'b0;
        write_next      = 1'b0;
        err_next        = 1'b0;
        clr_dout        = 1'b0;

`ifdef SPI_CMD_AUTOINC_EN
        // Post-increment after the write strobe so addr is stable while write is high.
        if (write_reg) begin
            addr_next = addr_reg + 1'b1;
        end
`endif

        if (byte_ok) begin
            case (state_reg)
                S_CMD: begin
                    if (illegal_cmd) begin
                        err_next   = 1'b1;
                        state_next = S_SKIP;
                    end else if (bus.data_in[7]) begin
                        addr_next  = bus.data_in[ADDR_W-1:0];
                        state_next = S_WDATA;
                    end else begin
                        addr_next  = bus.data_in[ADDR_W-1:0];
                        read_next  = 1'b1;
                        state_next = S_RDATA;
                    end
                end
                S_WDATA: begin
                    data_write_next = bus.data_in;
                    write_next      = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                    state_next      = S_WDATA;
`else
                    state_next      = S_CMD;
`endif
                end
                S_RDATA: begin
`ifdef SPI_CMD_AUTOINC_EN
                    addr_next  = addr_reg + 1'b1;
                    read_next  = 1'b1;
                    state_next = S_RDATA;
`else
                    clr_dout   = 1'b1;
                    state_next = S_CMD;
`endif
                end
                S_SKIP: begin
                    state_next = S_CMD;
                end
                default: begin
                    state_next = S_CMD;
                end
            endcase
        end

        if (bus.cs_n) begin
            state_next = S_CMD;
            clr_dout   = 1'b1;
        end
    end

    // cap marks the cycle in which data_read is valid for the last read strobe.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign cap = read_reg;
        end else begin : g_lat1
            logic cap_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cap_reg <= 1'b0;
                end else begin
                    cap_reg <= read_reg;
                end
            end
            assign cap = cap_reg;
        end
    endgenerate

    always_comb begin
        data_out_next = data_out_reg;
        if (cap) begin
            data_out_next = bus.data_read;
        end else if (clr_dout) begin
            data_out_next = 8'h00;
        end
    end

    // Bypass in the capture cycle so data_out reflects data_read right away,
    // then the register holds it until the next load or clear.
    assign bus.data_out   = cap ? bus.data_read : data_out_reg;
    assign bus.addr       = addr_reg;
    assign bus.data_write = data_write_reg;
    assign bus.read       = read_reg;
    assign bus.write      = write_reg;
    assign bus.err        = err_reg;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: expected strobes are queued as bytes
// are driven and popped as the DUT issues read/write/err.
module tb_spi_cmd_decoder;

    localparam logic [2:0] K_RD = 3'b100;
    localparam logic [2:0] K_WR = 3'b010;
    localparam logic [2:0] K_ER = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];
    logic [7:0] mem [0:63];
    logic [7:0] rd_q;
    logic       rd_pend;
    logic [7:0] rd_exp;

    spi_cmd_decoder_if #(.ADDR_W(6)) bus ();

    spi_cmd_decoder #(
        .ADDR_W (6),
        .RD_LAT (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.read) rd_q <= mem[bus.addr];
    end
    assign bus.data_read = rd_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic push_rd(input logic [5:0] a);
        exp_t e;
        e.kind = K_RD; e.addr = a; e.data = mem[a];
        sb_q.push_back(e);
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = K_WR; e.addr = a; e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic push_err(input logic [5:0] a);
        exp_t e;
        e.kind = K_ER; e.addr = a; e.data = 8'h00;
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data_in   = b;
        bus.byte_sync = 1'b1;
        @(negedge clk);
        bus.byte_sync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops one expectation per strobe; read data checked a cycle later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_pend) begin
                check_eq("rd_data_out", bus.data_out, rd_exp);
                rd_pend = 1'b0;
            end
            if (bus.read || bus.write || bus.err) begin
                check_eq("strobe_exclusive", 32'(bus.read & bus.write), 0);
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_strobe", {bus.read, bus.write, bus.err}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("strobe_kind", {bus.read, bus.write, bus.err}, e.kind);
                    check_eq("strobe_addr", bus.addr, e.addr);
                    if (e.kind == K_WR) check_eq("write_data", bus.data_write, e.data);
                    if (e.kind == K_RD) begin
                        rd_pend = 1'b1;
                        rd_exp  = e.data;
                    end
                end
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rd_pend      = 1'b0;
        rd_exp       = 8'h00;
        rd_q         = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'h3F ^ 8'(i);
        rst_n         = 1'b0;
        bus.cs_n      = 1'b1;
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_read", bus.read, 0);
        check_eq("rst_write", bus.write, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_addr", bus.addr, 0);
        check_eq("rst_data_write", bus.data_write, 0);
        check_eq("rst_data_out", bus.data_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Illegal command: err with addr unchanged, next byte swallowed.
        frame_begin();
        push_err(6'd0);
        push_wr(6'd1, 8'h22);
        send_byte(8'h40);
        send_byte(8'h11);
        send_byte(8'h81);
        send_byte(8'h22);
        frame_end();

        // Plain write.
        frame_begin();
        push_wr(6'd5, 8'hA5);
        send_byte(8'h85);
        send_byte(8'hA5);
        frame_end();

        // Read with data_out check, then dummy byte.
        frame_begin();
        push_rd(6'd3);
        send_byte(8'h03);
        check_eq("rd_hold", bus.data_out, 8'h3C);
`ifdef SPI_CMD_AUTOINC_EN
        push_rd(6'd4);
        send_byte(8'h00);
`else
        send_byte(8'h00);
        check_eq("dummy_clear", bus.data_out, 8'h00);
`endif
        frame_end();
        check_eq("csn_clear", bus.data_out, 8'h00);

        // Aborted write frame, then a fresh read frame.
        frame_begin();
        send_byte(8'h82);
        frame_end();
        frame_begin();
        push_rd(6'd1);
        send_byte(8'h01);
`ifdef SPI_CMD_AUTOINC_EN
        push_rd(6'd2);
`endif
        send_byte(8'h00);
        frame_end();

        // Data byte arriving with cs_n rising is still written.
        frame_begin();
        push_wr(6'd4, 8'h77);
        send_byte(8'h84);
        @(negedge clk);
        bus.data_in   = 8'h77;
        bus.byte_sync = 1'b1;
        bus.cs_n      = 1'b1;
        @(negedge clk);
        bus.byte_sync = 1'b0;
        repeat (6) @(negedge clk);

        // Byte while cs_n is idle high is ignored.
        send_byte(8'h85);
        frame_begin();
        push_rd(6'd3);
        send_byte(8'h03);
`ifdef SPI_CMD_AUTOINC_EN
        push_rd(6'd4);
`endif
        send_byte(8'h00);
        frame_end();

        // Reset while waiting for write data.
        frame_begin();
        push_wr(6'd2, 8'h5A);
        send_byte(8'h82);
        send_byte(8'h5A);
        frame_end();
        frame_begin();
        send_byte(8'h87);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_addr", bus.addr, 0);
        check_eq("arst_data_write", bus.data_write, 0);
        check_eq("arst_strobes", {bus.read, bus.write, bus.err}, 0);
        check_eq("arst_data_out", bus.data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_rd(6'd3);
        send_byte(8'h03);
`ifdef SPI_CMD_AUTOINC_EN
        push_rd(6'd4);
`endif
        send_byte(8'h00);
        frame_end();

`ifdef SPI_CMD_AUTOINC_EN
        // Burst write with address wrap.
        frame_begin();
        push_wr(6'd63, 8'h01);
        push_wr(6'd0, 8'h02);
        send_byte(8'hBF);
        send_byte(8'h01);
        send_byte(8'h02);
        frame_end();
`endif

        // New frame after any of the above starts from S_CMD.
        frame_begin();
        push_wr(6'd1, 8'h33);
        send_byte(8'h81);
        send_byte(8'h33);
        frame_end();

        repeat (10) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI bridge.
- Consumes each received byte (byte_sync/data_in) and decodes two-byte frames: command byte, then data byte.
- Issues single-cycle read/write strobes to the PWM register file.
- Returns read data to the bridge on data_out in time for the second byte's shift-out.

Parameters:
- ADDR_W, 6, register address width; 1..6, taken from cmd[ADDR_W-1:0]; cmd bits above ADDR_W up to bit 5 must be zero, else treated as illegal.
- RD_LAT, 1, register-file read latency in clk cycles from read strobe to valid data_read; legal values 0 or 1.

Ports:
- clk  input  1  peripheral clock.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  SPI chip select, already synchronised to clk; high ends or aborts the frame.
- byte_sync  input  1  one-cycle pulse; data_in holds a complete byte.
- data_in  input  8  received byte.
- data_out  output  8  byte the bridge shifts out on MISO during the next byte.
- read  output  1  one-cycle register read strobe.
- write  output  1  one-cycle register write strobe.
- addr  output  ADDR_W  register address, stable while read/write are high.
- data_read  input  8  register-file read data.
- data_write  output  8  register write data, valid while write is high.
- err  output  1  one-cycle pulse on an illegal command byte.

Behaviour:
- Reset (async, rst_n low): state=S_CMD. read, write and err are 0. addr, data_write and data_out are 0.
- Command byte format: bit7 = 1 write, 0 read; bit6 reserved and must be 0; bits5:0 address.
- Illegal command: bit6=1, or nonzero bits in [5:ADDR_W].
- States: S_CMD, S_WDATA, S_RDATA, S_SKIP. Only byte_sync advances state.
- Cycle N below is the cycle byte_sync is high.
- S_CMD:
  - Legal write command: addr<=cmd address at N+1; goto S_WDATA.
  - Legal read command: addr<=cmd address and read=1 at N+1; goto S_RDATA.
  - data_out<=data_read at cycle N+1+RD_LAT and is held until the next load.
  - Illegal command: err=1 at N+1; goto S_SKIP; addr unchanged.
- S_WDATA + byte_sync: data_write<=data_in and write=1 at N+1; goto S_CMD.
- S_RDATA + byte_sync: the dummy byte is discarded; data_out<=0x00; goto S_CMD.
- S_SKIP + byte_sync: byte discarded, no strobe; goto S_CMD.
- cs_n high:
  - Forces state to S_CMD on the next cycle.
  - No write is ever issued without a complete data byte.
  - Strobes already scheduled still complete.
  - data_out<=0x00.
- byte_sync and cs_n rising in the same cycle: the byte is processed normally; state still returns to S_CMD.
- Strobes never overlap; read and write are never high together.
- Bridge timing margin: at least 4 clk per SCLK half-period guarantees data_out is valid before the first bit of the data byte.
- byte_sync received while cs_n is high is ignored.

Optional Feature:
- Macro: SPI_CMD_AUTOINC_EN.
- Defined: burst mode.
  - After each data byte in S_WDATA or S_RDATA, stay in the same state and set addr<=addr+1, wrapping from 2^ADDR_W-1 to 0.
  - In S_RDATA, each byte_sync issues read for the incremented address at N+1, with data_out reloaded at N+1+RD_LAT.
  - The frame ends only when cs_n goes high.
- Undefined: exactly one data byte per frame, as described above; addr never increments.

Test Plan:
- Frame 0x85, 0xA5 → write pulse one cycle at N+1 with addr=5 and data_write=0xA5; state back to S_CMD; no read or err.
- Frame 0x03 with data_read=0x3C (RD_LAT=1) → read pulse at N+1 with addr=3; data_out=0x3C by N+2; after the dummy byte, data_out=0x00.
- 0x82, then cs_n high, then new frame 0x01 → no write ever; read pulse with addr=1.
- 0x40, 0x11, 0x81, 0x22 → err pulse after the first byte; 0x11 swallowed; write with addr=1 and data_write=0x22.
- rst_n low while in S_WDATA → all outputs 0 immediately; next byte treated as a command.
- SPI_CMD_AUTOINC_EN defined: 0xBF, 0x01, 0x02 (ADDR_W=6) → writes at addr 63 with 0x01, then addr 0 with 0x02 (wrap); cs_n high returns to S_CMD.
